// File: rtl/dram_multibank_cmd_fsm.sv
// Multi-bank DRAM command sequencer: per-bank open-row and tRCD/tRP/tRAS tracking,
// one registered command per cycle, open/closed page policy and refresh sequencing.

module dram_bank_state #(
  parameter int ROW_W = 14,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TRAS  = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             open_o,
  output logic [ROW_W-1:0] row_o,
  output logic             rcd_ok_o,
  output logic             rp_ok_o,
  output logic             ras_ok_o
);
  localparam int TMAX = (TRAS > TRP) ? ((TRAS > TRCD) ? TRAS : TRCD)
                                     : ((TRP > TRCD) ? TRP : TRCD);
  localparam int CW = $clog2(TMAX) + 1;

  logic [CW-1:0]    act_cnt_q, pre_cnt_q;
  logic             open_q;
  logic [ROW_W-1:0] row_q;

  // Counters read "cycles since the command was on the bus"; an ok flag means a
  // command decided now (and so issued next cycle) meets the constraint.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      open_q    <= 1'b0;
      row_q     <= '0;
      act_cnt_q <= '1;
      pre_cnt_q <= '1;
    end else begin
      if (act_i) begin
        open_q <= 1'b1;
        row_q  <= row_i;
      end else if (pre_i) begin
        open_q <= 1'b0;
      end
      act_cnt_q <= act_i ? '0 : (&act_cnt_q ? act_cnt_q : act_cnt_q + 1'b1);
      pre_cnt_q <= pre_i ? '0 : (&pre_cnt_q ? pre_cnt_q : pre_cnt_q + 1'b1);
    end
  end

  assign open_o   = open_q;
  assign row_o    = row_q;
  assign rcd_ok_o = act_cnt_q >= CW'(TRCD - 1);
  assign ras_ok_o = act_cnt_q >= CW'(TRAS - 1);
  assign rp_ok_o  = pre_cnt_q >= CW'(TRP - 1);
endmodule

module dram_multibank_cmd_fsm #(
  parameter int NBANKS    = 4,
  parameter int ROW_W     = 14,
  parameter int TRCD      = 3,
  parameter int TRP       = 3,
  parameter int TRAS      = 8,
  parameter int TRFC      = 16,
  parameter int OPEN_PAGE = 1,
  localparam int BANK_W   = $clog2(NBANKS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic              ref_req,
  output logic              ref_ack,
  output logic              cmd_valid,
  output logic [2:0]        cmd_op,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic              rw_done,
  output logic [NBANKS-1:0] bank_open
);
  localparam int RFW = $clog2(TRFC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_REF_CLOSE, S_REF_WAIT_RP, S_REF_ISSUE, S_REF_WAIT_RFC
  } state_e;
  typedef enum logic [1:0] {PH_ACC, PH_APRE, PH_DONE} phase_e;
  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3, OP_PRE = 3'd4, OP_REF = 3'd5
  } op_e;

  state_e state_q, state_d;
  phase_e phase_q, phase_d;
  logic              wr_q, wr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [RFW-1:0]    rfc_q, rfc_d;
  op_e               op_q, op_d;
  logic [BANK_W-1:0] ob_q, ob_d;
  logic [ROW_W-1:0]  orow_q, orow_d;
  logic              ack_q, ack_d;

  logic [NBANKS-1:0]            act_vec, pre_vec, open_vec, rcd_ok, rp_ok, ras_ok;
  logic [NBANKS-1:0][ROW_W-1:0] open_row;
  logic              serve_acc, any_open;
  logic [BANK_W-1:0] close_sel, eff_bank;
  logic [ROW_W-1:0]  eff_row;
  logic              eff_write;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    dram_bank_state #(.ROW_W(ROW_W), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS)) u_bank (
      .CLK(CLK), .nRST(nRST), .act_i(act_vec[b]), .pre_i(pre_vec[b]), .row_i(eff_row),
      .open_o(open_vec[b]), .row_o(open_row[b]), .rcd_ok_o(rcd_ok[b]),
      .rp_ok_o(rp_ok[b]), .ras_ok_o(ras_ok[b])
    );
  end

  assign req_ready = (state_q == S_IDLE) && !ref_req;
  // In IDLE the handshake cycle itself decides the first command from live inputs.
  assign eff_bank  = (state_q == S_IDLE) ? req_bank  : bank_q;
  assign eff_row   = (state_q == S_IDLE) ? req_row   : row_q;
  assign eff_write = (state_q == S_IDLE) ? req_write : wr_q;

  always_comb begin
    any_open  = 1'b0;
    close_sel = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (open_vec[i]) begin
        any_open  = 1'b1;
        close_sel = BANK_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wr_d      = wr_q;
    bank_d    = bank_q;
    row_d     = row_q;
    rfc_d     = '0;
    op_d      = OP_NOP;
    ob_d      = '0;
    orow_d    = '0;
    ack_d     = 1'b0;
    serve_acc = 1'b0;
    act_vec   = '0;
    pre_vec   = '0;
    case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          state_d = S_REF_CLOSE;
        end else if (req_valid) begin
          state_d   = S_SERVE;
          phase_d   = PH_ACC;
          wr_d      = req_write;
          bank_d    = req_bank;
          row_d     = req_row;
          serve_acc = 1'b1;
        end
      end
      S_SERVE: begin
        case (phase_q)
          PH_ACC:  serve_acc = 1'b1;
          PH_APRE: if (ras_ok[bank_q]) begin
            op_d    = OP_PRE;
            ob_d    = bank_q;
            phase_d = PH_DONE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_REF_CLOSE: begin
        if (!any_open) state_d = S_REF_WAIT_RP;
        else if (ras_ok[close_sel]) begin
          op_d = OP_PRE;
          ob_d = close_sel;
        end
      end
      S_REF_WAIT_RP: if (&rp_ok) begin
        op_d    = OP_REF;
        state_d = S_REF_ISSUE;
      end
      S_REF_ISSUE: begin
        rfc_d   = rfc_q + 1'b1;
        state_d = S_REF_WAIT_RFC;
      end
      S_REF_WAIT_RFC: begin
        rfc_d = rfc_q + 1'b1;
        if (rfc_q == RFW'(TRFC - 1)) ack_d = 1'b1;
        if (rfc_q == RFW'(TRFC)) begin
          rfc_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (serve_acc) begin
      if (!open_vec[eff_bank]) begin
        if (rp_ok[eff_bank]) begin
          op_d   = OP_ACT;
          ob_d   = eff_bank;
          orow_d = eff_row;
        end
      end else if (open_row[eff_bank] == eff_row) begin
        if (rcd_ok[eff_bank]) begin
          op_d    = eff_write ? OP_WR : OP_RD;
          ob_d    = eff_bank;
          phase_d = (OPEN_PAGE != 0) ? PH_DONE : PH_APRE;
        end
      end else if (ras_ok[eff_bank]) begin
        op_d = OP_PRE;
        ob_d = eff_bank;
      end
    end

    if (op_d == OP_ACT) act_vec[ob_d] = 1'b1;
    if (op_d == OP_PRE) pre_vec[ob_d] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      phase_q <= PH_ACC;
      wr_q    <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      rfc_q   <= '0;
      op_q    <= OP_NOP;
      ob_q    <= '0;
      orow_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      rfc_q   <= rfc_d;
      op_q    <= op_d;
      ob_q    <= ob_d;
      orow_q  <= orow_d;
      ack_q   <= ack_d;
    end
  end

  assign cmd_valid = (op_q != OP_NOP);
  assign cmd_op    = op_q;
  assign cmd_bank  = ob_q;
  assign cmd_row   = orow_q;
  assign rw_done   = (op_q == OP_RD) || (op_q == OP_WR);
  assign ref_ack   = ack_q;
  assign bank_open = open_vec;
endmodule

// File: tb/tb_dram_multibank_cmd_fsm.sv
// Scoreboard bench: directed requests push expected commands (cycle, op, bank, row);
// a negedge monitor pops and compares whenever a command or ref_ack appears.

module tb_dram_multibank_cmd_fsm;
  localparam int BW = 2, RW = 14, TRAS = 8, TRFC = 16;
  localparam int ACT = 1, RD = 2, WR = 3, PRE = 4, REF = 5, ACK = 6;

  logic          CLK = 1'b0, nRST = 1'b0;
  logic          rv0 = 1'b0, rv1 = 1'b0, req_write = 1'b0, ref_req = 1'b0;
  logic [BW-1:0] req_bank = '0;
  logic [RW-1:0] req_row = '0;
  logic rdy0, ack0, cv0, rwd0, rdy1, ack1, cv1, rwd1;
  logic [2:0]    op0, op1;
  logic [BW-1:0] cb0, cb1;
  logic [RW-1:0] cr0, cr1;
  logic [3:0]    bo0, bo1;

  typedef struct { int cyc; int op; int bank; int row; } exp_t;
  exp_t q0[$], q1[$];
  int cyc = 0, total = 0, bad = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dram_multibank_cmd_fsm #(.OPEN_PAGE(1)) dut0 (
    .CLK(CLK), .nRST(nRST), .req_valid(rv0), .req_ready(rdy0), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .ref_req(ref_req), .ref_ack(ack0),
    .cmd_valid(cv0), .cmd_op(op0), .cmd_bank(cb0), .cmd_row(cr0), .rw_done(rwd0),
    .bank_open(bo0));

  dram_multibank_cmd_fsm #(.OPEN_PAGE(0)) dut1 (
    .CLK(CLK), .nRST(nRST), .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .ref_req(1'b0), .ref_ack(ack1),
    .cmd_valid(cv1), .cmd_op(op1), .cmd_bank(cb1), .cmd_row(cr1), .rw_done(rwd1),
    .bank_open(bo1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int inst, input int c, input int op, input int b, input int r);
    exp_t e;
    e.cyc = c; e.op = op; e.bank = b; e.row = r;
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pop_cmp(input int inst, input int op, input int b, input int r);
    exp_t e;
    int sz;
    sz = (inst == 0) ? q0.size() : q1.size();
    total++;
    if (sz == 0) begin
      bad++;
      $display("FAIL dut%0d unexpected event op=%0d bank=%0d row=%0h at cycle %0d", inst, op, b, r, cyc);
    end else begin
      if (inst == 0) e = q0.pop_front(); else e = q1.pop_front();
      if (e.cyc != cyc || e.op != op || e.bank != b || e.row != r) begin
        bad++;
        $display("FAIL dut%0d event got cyc=%0d op=%0d bank=%0d row=%0h exp cyc=%0d op=%0d bank=%0d row=%0h",
                 inst, cyc, op, b, r, e.cyc, e.op, e.bank, e.row);
      end
    end
  endtask

  task automatic mon(input int inst, input logic cv, input logic [2:0] op, input logic [BW-1:0] b,
                     input logic [RW-1:0] r, input logic rwd, input logic ack);
    if (cv) pop_cmp(inst, int'(op), int'(b), int'(r));
    else chk($sformatf("dut%0d idle_bus_zero", inst), {29'd0, |op, |b, |r}, 32'd0);
    if (cv || rwd) chk($sformatf("dut%0d rw_done", inst), {31'd0, rwd}, {31'd0, cv && (op == 3'd2 || op == 3'd3)});
    if (ack) pop_cmp(inst, ACK, 0, 0);
  endtask

  always @(negedge CLK) begin
    mon(0, cv0, op0, cb0, cr0, rwd0, ack0);
    mon(1, cv1, op1, cb1, cr1, rwd1, ack1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present a request and return the handshake cycle; valid drops after the handshake.
  task automatic send(input int inst, input logic w, input int b, input int r, output int hs);
    int n;
    req_write = w; req_bank = BW'(b); req_row = RW'(r);
    if (inst == 0) rv0 = 1'b1; else rv1 = 1'b1;
    hs = -1;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if ((inst == 0) ? rdy0 : rdy1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      total++; bad++;
      $display("FAIL dut%0d handshake timeout", inst);
    end
    @(posedge CLK); #1;
    rv0 = 1'b0; rv1 = 1'b0;
  endtask

  initial begin
    int ha, h2, h3, h4, h5, h6, h7, g, r, pre_t, n;
    logic early;
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_dut0_outputs", {5'd0, cv0, op0, cb0, cr0, rwd0, ack0, bo0, rdy0}, 32'd1);
    chk("reset_dut1_outputs", {5'd0, cv1, op1, cb1, cr1, rwd1, ack1, bo1, rdy1}, 32'd1);
    @(posedge CLK); #1 nRST = 1'b1;
    tick(2);

    // Cold read: ACT at +1, RD at +1+TRCD
    send(0, 1'b0, 2, 'h55, ha);
    push(0, ha + 1, ACT, 2, 'h55);
    push(0, ha + 4, RD, 2, 0);
    // Row hit
    send(0, 1'b0, 2, 'h55, h2);
    chk("cold_read_ready_cycle", h2, ha + 5);
    push(0, h2 + 1, RD, 2, 0);
    chk("bank_open_after_cold", {28'd0, bo0}, 32'b0100);
    // Row miss: PRE held off by tRAS from the first ACT
    send(0, 1'b0, 2, 'h66, h3);
    chk("hit_ready_cycle", h3, h2 + 2);
    pre_t = (h3 + 1 > ha + 1 + TRAS) ? h3 + 1 : ha + 1 + TRAS;
    push(0, pre_t, PRE, 2, 0);
    push(0, pre_t + 3, ACT, 2, 'h66);
    push(0, pre_t + 6, RD, 2, 0);

    // Reset mid-SERVE: only the ACT makes it out
    send(0, 1'b0, 1, 9, h4);
    push(0, h4 + 1, ACT, 1, 9);
    tick(1);
    nRST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("midreset_outputs", {5'd0, cv0, op0, cb0, cr0, rwd0, ack0, bo0, rdy0}, 32'd1);
    end
    @(posedge CLK); #1 nRST = 1'b1;
    tick(1);

    // Open banks 0 and 3, let tRAS elapse, then refresh from IDLE
    send(0, 1'b0, 0, 1, h4);
    push(0, h4 + 1, ACT, 0, 1);
    push(0, h4 + 4, RD, 0, 0);
    send(0, 1'b1, 3, 2, h5);
    chk("second_open_handshake", h5, h4 + 5);
    push(0, h5 + 1, ACT, 3, 2);
    push(0, h5 + 4, WR, 3, 0);
    tick(12);
    chk("banks_0_3_open", {28'd0, bo0}, 32'b1001);
    ref_req = 1'b1;
    r = cyc;
    push(0, r + 2, PRE, 0, 0);
    push(0, r + 3, PRE, 3, 0);
    push(0, r + 6, REF, 0, 0);
    push(0, r + 6 + TRFC, ACK, 0, 0);
    @(negedge CLK);
    chk("ready_low_on_ref_req", {31'd0, rdy0}, 32'd0);
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (ack0) break;
    end
    if (n == 100) begin total++; bad++; $display("FAIL ref_ack timeout"); end
    ref_req = 1'b0;
    @(negedge CLK);
    chk("ready_after_ref_ack", {31'd0, rdy0}, 32'd1);
    chk("all_closed_after_ref", {28'd0, bo0}, 32'd0);

    // Refresh raised during SERVE: pending RD first, held request waits for ref_ack
    @(posedge CLK); #1;
    req_write = 1'b0; req_bank = 2'd1; req_row = 14'd4; rv0 = 1'b1;
    h6 = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (rdy0) begin h6 = cyc; break; end
    end
    push(0, h6 + 1, ACT, 1, 4);
    push(0, h6 + 4, RD, 1, 0);
    push(0, h6 + 9, PRE, 1, 0);
    push(0, h6 + 12, REF, 0, 0);
    push(0, h6 + 12 + TRFC, ACK, 0, 0);
    push(0, h6 + 14 + TRFC, ACT, 1, 4);
    push(0, h6 + 17 + TRFC, RD, 1, 0);
    @(posedge CLK); #1 ref_req = 1'b1;
    early = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (rdy0) early = 1'b1;
      if (ack0) break;
    end
    if (n == 100) begin total++; bad++; $display("FAIL ref_ack timeout in serve case"); end
    ref_req = 1'b0;
    chk("no_accept_before_ack", {31'd0, early}, 32'd0);
    h7 = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (rdy0) begin h7 = cyc; break; end
    end
    chk("held_req_accept_cycle", h7, h6 + 13 + TRFC);
    @(posedge CLK); #1 rv0 = 1'b0;
    tick(6);

    // Closed page on dut1: WR then auto-PRE once tRAS is met
    send(1, 1'b1, 1, 7, g);
    push(1, g + 1, ACT, 1, 7);
    push(1, g + 4, WR, 1, 0);
    push(1, g + 9, PRE, 1, 0);
    tick(4);
    chk("closed_page_open_mid", {28'd0, bo1}, 32'b0010);
    tick(4);
    chk("closed_page_closed", {28'd0, bo1}, 32'd0);
    h7 = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (rdy1) begin h7 = cyc; break; end
    end
    chk("closed_page_ready_cycle", h7, g + 10);

    tick(5);
    chk("dut0_queue_drained", q0.size(), 32'd0);
    chk("dut1_queue_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
